// File: rtl/ddr_req_arbiter.sv
// rtl/ddr_req_arbiter.sv - round-robin sequencer sharing one DDR request port among NUM_REQ clients
module ddr_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk_sys_200mhz,
    input  logic                      reset_por_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_error,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_write_data,
    output logic                      mem_write_enable,
    output logic                      mem_read_enable,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_read_data,
    output logic                      busy,
    output logic [2:0]                grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2:0]          ptr;
    logic [2:0]          pick;
    logic                found;
    logic [15:0]         wdog;
    logic                hold_write;
    logic                issue_active;
    logic                done_ok;
    logic                done_timeout;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;

    // First pass favours requesters at/after the pointer; second pass handles the wrap.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (3'(i) >= ptr)) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == 3'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_write = req_write[i];
            end
        end
    end

    assign issue_active = mem_write_enable | mem_read_enable;
    assign done_ok      = issue_active && mem_ready;
    assign done_timeout = issue_active && !mem_ready && (wdog == 16'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = ISSUE;
            ISSUE:   if (done_ok || done_timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_200mhz or negedge reset_por_n) begin
        if (!reset_por_n) begin
            state            <= IDLE;
            ptr              <= '0;
            wdog             <= '0;
            hold_write       <= 1'b0;
            req_ready        <= '0;
            rsp_valid        <= '0;
            rsp_rdata        <= '0;
            rsp_error        <= 1'b0;
            mem_addr         <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            busy             <= 1'b0;
            grant_id         <= '0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        req_ready      <= NUM_REQ'(1) << pick;
                        grant_id       <= pick;
                        ptr            <= (pick == 3'(NUM_REQ - 1)) ? 3'd0 : pick + 3'd1;
                        mem_addr       <= sel_addr;
                        mem_write_data <= sel_wdata;
                        hold_write     <= sel_write;
                        wdog           <= '0;
                    end
                end
                ISSUE: begin
                    // The first ISSUE cycle raises the strobe, so it appears one cycle after req_ready.
                    if (!issue_active) begin
                        mem_write_enable <= hold_write;
                        mem_read_enable  <= !hold_write;
                    end else if (done_ok) begin
                        mem_write_enable <= 1'b0;
                        mem_read_enable  <= 1'b0;
                        rsp_rdata        <= mem_read_enable ? mem_read_data : '0;
                        rsp_error        <= 1'b0;
                        rsp_valid        <= NUM_REQ'(1) << grant_id;
                    end else if (done_timeout) begin
                        mem_write_enable <= 1'b0;
                        mem_read_enable  <= 1'b0;
                        rsp_rdata        <= '0;
                        rsp_error        <= 1'b1;
                        rsp_valid        <= NUM_REQ'(1) << grant_id;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb/tb_ddr_req_arbiter.sv - randomized self-checking bench for ddr_req_arbiter
module tb_ddr_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int TO = 24;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, mem_write_data, mem_read_data;
    logic            rsp_error, mem_write_enable, mem_read_enable, mem_ready, busy;
    logic [AW-1:0]   mem_addr;
    logic [2:0]      grant_id;

    int n_tests = 0;
    int n_fail  = 0;
    int mptr    = 0;

    ddr_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_sys_200mhz(clk), .reset_por_n(rstn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_ready(mem_ready), .mem_read_data(mem_read_data),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Round-robin reference: first pending requester at or after the pointer, wrapping.
    function automatic int model_pick(input int p, input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic wait_ready(output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
            end
        end
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        mptr = 0;
        @(negedge clk);
    endtask

    task automatic drain();
        req_valid = '0;
        mem_ready = 1'b1;
        repeat (6) @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic bad;
        rstn = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_write_data,
             mem_write_enable, mem_read_enable, busy, grant_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero (busy=%b en=%b%b grant=%0d) want all 0",
                     busy, mem_write_enable, mem_read_enable, grant_id);
        end
        rstn = 1'b1;
        bad  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || mem_write_enable || mem_read_enable || req_ready != '0 || rsp_valid != '0) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: activity seen=%b want 0", bad);
        end
    endtask

    task automatic test_single_read();
        int g;
        bit ok;
        do_reset();
        req_write           = '0;
        req_addr[2*AW +: AW] = 32'h1000;
        req_valid           = 4'b0100;
        wait_ready(g, ok);
        req_valid = '0;
        n_tests++;
        if (!ok || req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL read_grant: req_ready=%b want 0100", req_ready);
        end
        @(negedge clk);
        n_tests++;
        if (mem_read_enable !== 1'b1 || mem_write_enable !== 1'b0 || mem_addr !== 32'h1000) begin
            n_fail++;
            $display("FAIL read_issue: rd=%b wr=%b addr=%h want 1 0 1000",
                     mem_read_enable, mem_write_enable, mem_addr);
        end
        @(negedge clk);
        mem_ready     = 1'b1;
        mem_read_data = {16{8'hA5}};
        @(negedge clk);
        mem_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 4'b0100 || rsp_rdata !== {16{8'hA5}} || rsp_error !== 1'b0 || mem_read_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp: rsp_valid=%b rdata=%h err=%b want 0100 a5.. 0",
                     rsp_valid, rsp_rdata, rsp_error);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp_pulse: rsp_valid=%b busy=%b want 0000 0", rsp_valid, busy);
        end
    endtask

    task automatic test_fairness();
        int seen[$];
        int e;
        do_reset();
        req_write     = 4'b1010;
        mem_read_data = rand128();
        req_valid     = 4'b1111;
        mem_ready     = 1'b1;
        for (int c = 0; c < 200 && seen.size() < 8; c++) begin
            @(negedge clk);
            if (req_ready != '0) seen.push_back(int'(grant_id));
        end
        req_valid = '0;
        repeat (6) @(negedge clk);
        mem_ready = 1'b0;
        n_tests++;
        if (seen.size() != 8) begin
            n_fail++;
            $display("FAIL fair_count: grants=%0d want 8", seen.size());
        end
        for (int i = 0; i < seen.size(); i++) begin
            e    = model_pick(mptr, 4'b1111);
            mptr = (e + 1) % N;
            n_tests++;
            if (seen[i] != e) begin
                n_fail++;
                $display("FAIL fair_order[%0d]: grant=%0d want %0d", i, seen[i], e);
            end
        end
    endtask

    task automatic test_write_backpressure();
        int g;
        bit ok;
        logic stable;
        do_reset();
        req_write             = 4'b0010;
        req_addr[1*AW +: AW]  = 32'h20;
        req_wdata[1*DW +: DW] = 128'h1234;
        mem_read_data         = rand128();
        req_valid             = 4'b0010;
        wait_ready(g, ok);
        req_valid = '0;
        n_tests++;
        if (!ok || g != 1) begin
            n_fail++;
            $display("FAIL wr_grant: idx=%0d want 1", g);
        end
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (mem_write_enable !== 1'b1 || mem_read_enable !== 1'b0 ||
                mem_addr !== 32'h20 || mem_write_data !== 128'h1234 || rsp_valid !== '0) stable = 1'b0;
        end
        n_tests++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_hold: stable=%b want 1", stable);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 4'b0010 || rsp_rdata !== '0 || rsp_error !== 1'b0 || mem_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rsp: rsp_valid=%b rdata=%h err=%b wr=%b want 0010 0 0 0",
                     rsp_valid, rsp_rdata, rsp_error, mem_write_enable);
        end
    endtask

    task automatic test_timeout();
        int g, cnt;
        bit ok;
        do_reset();
        req_write     = '0;
        mem_read_data = rand128();
        req_valid     = 4'b1000;
        wait_ready(g, ok);
        req_valid = '0;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (mem_read_enable) cnt++;
            else if (cnt > 0) break;
        end
        n_tests++;
        if (!ok || cnt != TO) begin
            n_fail++;
            $display("FAIL timeout_len: enable cycles=%0d want %0d", cnt, TO);
        end
        n_tests++;
        if (rsp_valid !== 4'b1000 || rsp_error !== 1'b1 || rsp_rdata !== '0) begin
            n_fail++;
            $display("FAIL timeout_rsp: rsp_valid=%b err=%b rdata=%h want 1000 1 0",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_issue();
        int g;
        bit ok;
        logic quiet;
        do_reset();
        req_write = '0;
        req_valid = 4'b0100;
        wait_ready(g, ok);
        req_valid = '0;
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        n_tests++;
        if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: rd=%b wr=%b busy=%b want 0 0 0",
                     mem_read_enable, mem_write_enable, busy);
        end
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== '0) quiet = 1'b0;
        end
        rstn      = 1'b1;
        req_valid = 4'b1001;
        wait_ready(g, ok);
        req_valid = '0;
        n_tests++;
        if (!ok || g != 0 || quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_grant: idx=%0d quiet=%b want 0 1", g, quiet);
        end
        drain();
    endtask

    task automatic test_random();
        logic [N-1:0]  mask;
        logic [AW-1:0] ad[N];
        logic [DW-1:0] wd[N];
        logic [DW-1:0] rd;
        int g, e, d;
        bit ok;
        do_reset();
        for (int it = 0; it < 30; it++) begin
            mask      = 4'($urandom_range(1, 15));
            req_write = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                ad[i] = $urandom;
                wd[i] = rand128();
                req_addr[i*AW +: AW]  = ad[i];
                req_wdata[i*DW +: DW] = wd[i];
            end
            req_valid = mask;
            e    = model_pick(mptr, mask);
            mptr = (e + 1) % N;
            wait_ready(g, ok);
            req_valid = '0;
            n_tests++;
            if (!ok || g != e || int'(grant_id) != e) begin
                n_fail++;
                $display("FAIL rnd_grant[%0d]: idx=%0d grant_id=%0d want %0d", it, g, grant_id, e);
            end
            @(negedge clk);
            n_tests++;
            if (mem_write_enable !== req_write[e] || mem_read_enable !== !req_write[e] ||
                mem_addr !== ad[e] || (req_write[e] && mem_write_data !== wd[e])) begin
                n_fail++;
                $display("FAIL rnd_issue[%0d]: wr=%b rd=%b addr=%h want wr=%b addr=%h",
                         it, mem_write_enable, mem_read_enable, mem_addr, req_write[e], ad[e]);
            end
            d = $urandom_range(0, 4);
            repeat (d) @(negedge clk);
            rd            = rand128();
            mem_read_data = rd;
            mem_ready     = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            n_tests++;
            if (rsp_valid !== (4'b0001 << e) || rsp_error !== 1'b0 ||
                rsp_rdata !== (req_write[e] ? '0 : rd)) begin
                n_fail++;
                $display("FAIL rnd_rsp[%0d]: rsp_valid=%b err=%b rdata=%h want idx %0d",
                         it, rsp_valid, rsp_error, rsp_rdata, e);
            end
        end
    endtask

    initial begin
        rstn          = 1'b0;
        req_valid     = '0;
        req_write     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        mem_ready     = 1'b0;
        mem_read_data = '0;
        test_reset();
        test_single_read();
        test_fairness();
        test_write_backpressure();
        test_timeout();
        test_reset_mid_issue();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
